// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the rv32_core slice.
// Holds the opcode, funct3 and funct7 encodings, the canonical NOP word,
// the register-file geometry and the ALU operation enum.
package rv32_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // ADDI x0,x0,0

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Multiply funct3 (OP_REG with F7_MULDIV)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // funct7
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd,
        AluMul,
        AluMulh,
        AluMulhsu,
        AluMulhu
    } alu_op_e;

endpackage

// File: rtl/rv32_regfile.sv
// rv32_regfile: 32 x 32-bit integer register file.
// Two combinational read ports, one synchronous write port. x0 reads as zero
// and ignores writes. Asynchronous active-low reset clears every register.
// Ports:
//   clk, rst            clock, async active-low reset
//   rs1_addr, rs2_addr  read addresses
//   rs1_data, rs2_data  read data (old value when written in the same cycle)
//   we, rd_addr, rd_data write enable, address, data (lands on rising clk)
module rv32_regfile
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] regs [0:REG_COUNT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd_addr != 5'd0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I integer core.
// Fetches from an external combinational ROM, executes one instruction per
// clock. Loads, stores, CSRs and unknown opcodes execute as NOPs.
// Optional feature macro: RV32M_MUL_EN adds MUL/MULH/MULHSU/MULHU.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   inst_i       instruction word at inst_addr_o
//   inst_addr_o  current PC (registered), RESET_PC after reset
module rv32_core
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_addr_o
);

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_e     alu_op;
    logic        rd_we, link, br_taken;
    logic [31:0] rd_wdata;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    assign pc_plus4 = pc_q + 32'd4;

    rv32_regfile u_regs (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (rd_we),
        .rd_addr  (rd),
        .rd_data  (rd_wdata)
    );

    // Branch condition
    always_comb begin
        br_taken = 1'b0;
        unique case (funct3)
            F3_BEQ:  br_taken = (rs1_data == rs2_data);
            F3_BNE:  br_taken = (rs1_data != rs2_data);
            F3_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
            F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: br_taken = (rs1_data < rs2_data);
            F3_BGEU: br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    // Decode: ALU operands/op, writeback enable and next PC
    always_comb begin
        alu_a  = rs1_data;
        alu_b  = rs2_data;
        alu_op = AluAdd;
        rd_we  = 1'b0;
        link   = 1'b0;
        pc_d   = pc_plus4;
        case (opcode)
            OP_LUI: begin
                alu_a = '0;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OP_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OP_JAL: begin
                rd_we = 1'b1;
                link  = 1'b1;
                pc_d  = pc_q + imm_j;
            end
            OP_JALR: begin
                alu_b = imm_i;
                rd_we = 1'b1;
                link  = 1'b1;
                pc_d  = {alu_res[31:1], 1'b0};
            end
            OP_BRANCH: begin
                if (br_taken) pc_d = pc_q + imm_b;
            end
            OP_IMM: begin
                alu_b = imm_i;
                rd_we = 1'b1;
                unique case (funct3)
                    F3_ADD_SUB: alu_op = AluAdd;
                    F3_SLT:     alu_op = AluSlt;
                    F3_SLTU:    alu_op = AluSltu;
                    F3_XOR:     alu_op = AluXor;
                    F3_OR:      alu_op = AluOr;
                    F3_AND:     alu_op = AluAnd;
                    F3_SLL: begin
                        alu_op = AluSll;
                        rd_we  = (funct7 == F7_BASE);
                    end
                    F3_SR: begin
                        alu_op = (funct7 == F7_ALT) ? AluSra : AluSrl;
                        rd_we  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default: rd_we = 1'b0;
                endcase
            end
            OP_REG: begin
                if (funct7 == F7_BASE) begin
                    rd_we = 1'b1;
                    unique case (funct3)
                        F3_ADD_SUB: alu_op = AluAdd;
                        F3_SLL:     alu_op = AluSll;
                        F3_SLT:     alu_op = AluSlt;
                        F3_SLTU:    alu_op = AluSltu;
                        F3_XOR:     alu_op = AluXor;
                        F3_SR:      alu_op = AluSrl;
                        F3_OR:      alu_op = AluOr;
                        F3_AND:     alu_op = AluAnd;
                        default:    rd_we  = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD_SUB) begin
                        alu_op = AluSub;
                        rd_we  = 1'b1;
                    end else if (funct3 == F3_SR) begin
                        alu_op = AluSra;
                        rd_we  = 1'b1;
                    end
`ifdef RV32M_MUL_EN
                end else if (funct7 == F7_MULDIV) begin
                    // funct3[2] set selects divide/remainder, left as NOP
                    rd_we = 1'b1;
                    unique case (funct3)
                        F3_MUL:    alu_op = AluMul;
                        F3_MULH:   alu_op = AluMulh;
                        F3_MULHSU: alu_op = AluMulhsu;
                        F3_MULHU:  alu_op = AluMulhu;
                        default:   rd_we  = 1'b0;
                    endcase
`endif
                end
            end
            // Loads, stores, FENCE, SYSTEM and unknown opcodes: NOP
            default: ;
        endcase
    end

    // ALU
`ifdef RV32M_MUL_EN
    logic [63:0] prod_ss, prod_su, prod_uu;
    // Low 64 bits of an extended 64x64 product equal the true signed product
    assign prod_ss = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
    assign prod_su = {{32{alu_a[31]}}, alu_a} * {32'b0, alu_b};
    assign prod_uu = {32'b0, alu_a} * {32'b0, alu_b};
`endif

    always_comb begin
        alu_res = '0;
        case (alu_op)
            AluAdd:    alu_res = alu_a + alu_b;
            AluSub:    alu_res = alu_a - alu_b;
            AluSll:    alu_res = alu_a << alu_b[4:0];
            AluSlt:    alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            AluSltu:   alu_res = {31'b0, alu_a < alu_b};
            AluXor:    alu_res = alu_a ^ alu_b;
            AluSrl:    alu_res = alu_a >> alu_b[4:0];
            AluSra:    alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            AluOr:     alu_res = alu_a | alu_b;
            AluAnd:    alu_res = alu_a & alu_b;
`ifdef RV32M_MUL_EN
            AluMul:    alu_res = prod_ss[31:0];
            AluMulh:   alu_res = prod_ss[63:32];
            AluMulhsu: alu_res = prod_su[63:32];
            AluMulhu:  alu_res = prod_uu[63:32];
`endif
            default:   alu_res = '0;
        endcase
    end

    assign rd_wdata = link ? pc_plus4 : alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign inst_addr_o = pc_q;

endmodule

// File: tb/tb_rv32_core.sv
// tb_rv32_core: directed self-checking bench for rv32_core.
// A small ROM indexed by inst_addr_o feeds inst_i. Expected values are queued
// when a program is launched and popped as the DUT state is sampled.
module tb_rv32_core;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_o;
    logic [31:0] rom [0:63];

    assign inst_i = rom[inst_addr_o[7:2]];

    rv32_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst_i),
        .inst_addr_o (inst_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   passes = 0;
    int   total  = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.value) passes++;
        else $error("FAIL %s: observed %h required %h", e.tag, obs, e.value);
    endtask

    // Encoders
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = NOP_INST;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_rom();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // ---------------- reset + four-word loop ----------------
        hold_reset();
        rom[0] = addi(5'd10, 5'd0, 32'd2);
        rom[1] = addi(5'd11, 5'd11, 32'd1);
        rom[2] = enc_r(7'b0000000, 5'd10, 5'd11, 3'b000, 5'd12);
        rom[3] = enc_r(7'b0100000, 5'd10, 5'd12, 3'b000, 5'd13);
        rom[4] = enc_j(32'hFFFF_FFF0, 5'd0);
        expect_val("reset_pc", 32'h0);
        expect_val("reset_x11", 32'h0);
        check(inst_addr_o);
        check(dut.u_regs.regs[11]);
        release_reset();
        for (int i = 0; i < 4; i++) expect_val("loop_pc", 32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            check(inst_addr_o);
            step(1);
        end
        expect_val("loop_x10", 32'd2);
        expect_val("loop_x11", 32'd1);
        expect_val("loop_x12", 32'd3);
        expect_val("loop_x13", 32'd1);
        check(dut.u_regs.regs[10]);
        check(dut.u_regs.regs[11]);
        check(dut.u_regs.regs[12]);
        check(dut.u_regs.regs[13]);
        expect_val("loop_back_pc", 32'h0);
        step(1);
        check(inst_addr_o);
        expect_val("loop2_x11", 32'd2);
        expect_val("loop2_x12", 32'd4);
        step(4);
        check(dut.u_regs.regs[11]);
        check(dut.u_regs.regs[12]);

        // ---------------- branches ----------------
        hold_reset();
        rom[0] = addi(5'd5, 5'd0, 32'hFFFF_FFFF);
        rom[1] = addi(5'd6, 5'd0, 32'd1);
        rom[2] = enc_b(32'd8, 5'd6, 5'd5, 3'b100);  // BLT at 0x08
        rom[4] = enc_b(32'd8, 5'd6, 5'd5, 3'b110);  // BLTU at 0x10
        release_reset();
        expect_val("blt_taken_pc", 32'h10);
        expect_val("bltu_not_taken_pc", 32'h14);
        step(3);
        check(inst_addr_o);
        step(1);
        check(inst_addr_o);

        // ---------------- jumps ----------------
        hold_reset();
        rom[0]  = enc_j(32'h20, 5'd0);
        rom[8]  = enc_j(32'd16, 5'd1);
        rom[12] = enc_i(32'd3, 5'd1, 3'b000, 5'd0, 7'b1100111);
        release_reset();
        expect_val("jal_pc", 32'h30);
        expect_val("jal_link", 32'h24);
        expect_val("jalr_pc", 32'h26);
        step(2);
        check(inst_addr_o);
        check(dut.u_regs.regs[1]);
        step(1);
        check(inst_addr_o);

        // ---------------- x0 and shifts ----------------
        hold_reset();
        rom[0] = addi(5'd0, 5'd0, 32'd5);
        rom[1] = enc_lui(20'h80000, 5'd8);
        rom[2] = enc_i({20'b0, 7'b0100000, 5'd31}, 5'd8, 3'b101, 5'd9, 7'b0010011);
        rom[3] = enc_i({20'b0, 7'b0000000, 5'd31}, 5'd8, 3'b101, 5'd14, 7'b0010011);
        rom[4] = enc_i(32'hFFFF_FFFF, 5'd0, 3'b011, 5'd15, 7'b0010011);  // SLTIU
        rom[5] = enc_i(32'h0, 5'd8, 3'b010, 5'd16, 7'b0010011);          // SLTI
        release_reset();
        expect_val("x0_stays_zero", 32'h0);
        expect_val("srai_31", 32'hFFFF_FFFF);
        expect_val("srli_31", 32'h1);
        expect_val("sltiu_sext", 32'h1);
        expect_val("slti_signed", 32'h1);
        step(6);
        check(dut.u_regs.regs[0]);
        check(dut.u_regs.regs[9]);
        check(dut.u_regs.regs[14]);
        check(dut.u_regs.regs[15]);
        check(dut.u_regs.regs[16]);

        // ---------------- multiply ----------------
        hold_reset();
        rom[0] = addi(5'd5, 5'd0, 32'hFFFF_FFFF);
        rom[1] = addi(5'd6, 5'd0, 32'd2);
        for (int i = 0; i < 4; i++) begin
            rom[2+i] = addi(5'(20 + i), 5'd0, 32'd7);
            rom[6+i] = enc_r(7'b0000001, 5'd6, 5'd5, 3'(i), 5'(20 + i));
        end
        release_reset();
`ifdef RV32M_MUL_EN
        expect_val("mul", 32'hFFFF_FFFE);
        expect_val("mulh", 32'hFFFF_FFFF);
        expect_val("mulhsu", 32'hFFFF_FFFF);
        expect_val("mulhu", 32'h1);
`else
        expect_val("mul_nop", 32'd7);
        expect_val("mulh_nop", 32'd7);
        expect_val("mulhsu_nop", 32'd7);
        expect_val("mulhu_nop", 32'd7);
`endif
        step(10);
        check(dut.u_regs.regs[20]);
        check(dut.u_regs.regs[21]);
        check(dut.u_regs.regs[22]);
        check(dut.u_regs.regs[23]);

        // ---------------- mid-run reset ----------------
        hold_reset();
        rom[0]  = addi(5'd10, 5'd0, 32'd9);
        rom[1]  = addi(5'd31, 5'd0, 32'hFFFF_FFFF);
        rom[2]  = enc_j(32'h38, 5'd0);  // 0x08 -> 0x40
        rom[16] = enc_j(32'h0, 5'd0);   // spin at 0x40
        release_reset();
        expect_val("pre_reset_pc", 32'h40);
        expect_val("pre_reset_x10", 32'd9);
        step(4);
        check(inst_addr_o);
        check(dut.u_regs.regs[10]);
        #2;
        rst = 1'b0;
        #1;
        expect_val("async_reset_pc", 32'h0);
        expect_val("async_reset_x10", 32'h0);
        expect_val("async_reset_x31", 32'h0);
        check(inst_addr_o);
        check(dut.u_regs.regs[10]);
        check(dut.u_regs.regs[31]);
        release_reset();
        expect_val("restart_pc", 32'h4);
        expect_val("restart_x10", 32'd9);
        step(1);
        check(inst_addr_o);
        check(dut.u_regs.regs[10]);

        if (sb.size() != 0) begin
            total++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
